wav_dfi_hs_checker: RTL
=======================

// Module: wav_dfi_hs_checker
// PURPOSE
//  Synthesizable, parametrised DFI req/ack handshake checker for NUM_CH channels
//  (lp_ctrl, lp_data, ctrlupd, phyupd, phymstr or any other req/ack pair).
//  It sits passively beside the DFI bus, in the PHY wrapper or an emulation build.
//  Per channel it tracks the handshake, enforces response and ack-release timing and
//  cross-channel ack exclusion. Violations go to sticky flags plus a saturating error
//  counter readable over CSR.
// PARAMETERS
//  NUM_CH     5          number of req/ack channels checked
//  CNT_W      8          width of cfg_tresp and the per-channel response counters
//  ERRCNT_W   16         width of err_count
//  CH_MODE    5'b00000   per channel: 0 = LP style (req may drop before ack), 1 = update style (ack mandatory)
//  EXCL_MASK  5'b11110   channels whose acks must never be high together
// PORTS
//  clock       in   1           DFI clock, all inputs sampled on posedge
//  reset       in   1           async, active-high
//  cfg_enable  in   1           0: all FSMs held in IDLE, no error logging
//  cfg_tresp   in   CNT_W       max consecutive req&~ack samples; 0 disables timeout check
//  err_clr     in   1           sync clear of err_flags and err_count
//  req         in   NUM_CH      per-channel request
//  ack         in   NUM_CH      per-channel acknowledge
//  ch_busy     out  NUM_CH      channel FSM != IDLE
//  err_flags   out  4*NUM_CH    sticky, per channel [4c+0]=TIMEOUT [4c+1]=PROTO [4c+2]=ACK_DROP [4c+3]=EXCL
//  err_any     out  1           OR of err_flags
//  err_count   out  ERRCNT_W    cycles with >=1 new error event, saturates at all-ones
// BEHAVIOUR
//  - Reset: every FSM is in IDLE, all counters are 0, and all outputs are 0.
//  - All outputs are registered. An error event sampled on edge N is visible after edge N.
//  - Per-channel FSM, using r=req[c] and a=ack[c] sampled each edge:
//    IDLE:  r&~a -> REQ, cnt=1.  r&a -> ACK (ack in the same cycle is legal).
//           ~r&a -> PROTO event, stay IDLE.
//    REQ:   r&~a: if cfg_tresp!=0 and cnt==cfg_tresp -> TIMEOUT event (once per transaction),
//           cnt holds. Otherwise cnt++.
//           r&a -> ACK.  ~r&~a -> IDLE; mode 1 also raises PROTO.  ~r&a -> REL.
//    ACK:   r&a stay.  ~r&a -> REL, rcnt=1.  ~r&~a -> IDLE.  r&~a -> PROTO event, -> REQ, cnt=1.
//    REL:   ~r&~a -> IDLE.  ~r&a: if rcnt==1 -> ACK_DROP event (once), rcnt saturates.
//           r&a -> PROTO event (req re-asserted before ack released), -> ACK.
//           r&~a -> REQ, cnt=1.
//  - Timing example: with cfg_tresp=3, req high with ack low on 4 consecutive edges
//    flags TIMEOUT on the 4th edge.
//  - Exclusion: on any edge where popcount(ack & EXCL_MASK) > 1, every channel with
//    ack high in that set gets its EXCL flag.
//  - err_count: +1 per edge with any new event on any channel. Several simultaneous
//    events still count as 1. The counter saturates and does not wrap.
//  - Flags are sticky: a repeated event on an already-set flag still increments err_count.
//  - err_clr: clears err_flags and err_count and has priority over events on the same
//    edge. FSMs are not affected.
//  - cfg_enable=0: FSMs and cnt/rcnt are forced to IDLE/0 and events are suppressed.
//    Flags and count hold. When cfg_enable rises while req is high, the FSM enters from
//    IDLE on the next edge.
//  - Reset mid-transaction: immediate return to reset state. No event is raised for the
//    aborted handshake.
//  - cnt and rcnt never wrap. cfg_tresp may change at any time and takes effect on the
//    next compare.
// TESTING
//  - LP legal: cfg_tresp=4, ch0 req 1-3 cycles, ack 2 cycles after req, req drops, ack
//    drops 1 cycle later -> err_any=0, ch_busy[0] back to 0.
//  - Timeout: cfg_tresp=3, ch0 req high 6 cycles with no ack -> err_flags[0]=1 on the
//    4th edge, err_count=1 (not 3).
//  - Update mode: CH_MODE[3]=1, req3 drops after 2 cycles without ack -> err_flags[13]=1.
//    Same stimulus on ch0 -> no error.
//  - Ack release: ch1 ack stays high 2 cycles after req falls -> err_flags[6]=1.
//    Req re-rises while ack is high -> err_flags[5]=1.
//  - Exclusion: ack[3] and ack[4] high on the same edge -> err_flags[15]=1 and
//    err_flags[19]=1, err_count+1. ack[0] together with ack[3] -> no EXCL.
//  - Saturation/clear: ERRCNT_W=2, 5 error edges -> err_count=3. err_clr together with
//    an event -> all 0. cfg_enable=0 during a bad handshake -> no change.

Source files
------------

// File: rtl/wav_dfi_hs_checker.sv
// Passive DFI req/ack handshake checker: per-channel protocol FSMs, response and
// ack-release timing, cross-channel ack exclusion, sticky flags and a saturating error count.
module wav_dfi_hs_checker #(
    parameter int                NUM_CH    = 5,
    parameter int                CNT_W     = 8,
    parameter int                ERRCNT_W  = 16,
    parameter logic [NUM_CH-1:0] CH_MODE   = 5'b00000,
    parameter logic [NUM_CH-1:0] EXCL_MASK = 5'b11110
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_cfg_enable,
    input  logic [CNT_W-1:0]      i_cfg_tresp,
    input  logic                  i_err_clr,
    input  logic [NUM_CH-1:0]     i_req,
    input  logic [NUM_CH-1:0]     i_ack,
    output logic [NUM_CH-1:0]     o_ch_busy,
    output logic [4*NUM_CH-1:0]   o_err_flags,
    output logic                  o_err_any,
    output logic [ERRCNT_W-1:0]   o_err_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2,
        ST_REL  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]    CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]    CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [ERRCNT_W-1:0] ERR_ZERO = {ERRCNT_W{1'b0}};
    localparam logic [ERRCNT_W-1:0] ERR_ONE  = {{(ERRCNT_W-1){1'b0}}, 1'b1};
    localparam logic [ERRCNT_W-1:0] ERR_MAX  = {ERRCNT_W{1'b1}};

    // True when more than one bit of the vector is set.
    function automatic logic multi_hot(input logic [NUM_CH-1:0] v);
        return (v & (v - {{(NUM_CH-1){1'b0}}, 1'b1})) != {NUM_CH{1'b0}};
    endfunction

    state_t               r_state     [NUM_CH];
    state_t               w_state_nxt [NUM_CH];
    logic [CNT_W-1:0]     r_cnt       [NUM_CH];
    logic [CNT_W-1:0]     w_cnt_nxt   [NUM_CH];
    logic [1:0]           r_rcnt      [NUM_CH];
    logic [1:0]           w_rcnt_nxt  [NUM_CH];
    logic [NUM_CH-1:0]    r_tdone;
    logic [NUM_CH-1:0]    w_tdone_nxt;

    logic [NUM_CH-1:0]    w_ev_tout;
    logic [NUM_CH-1:0]    w_ev_proto;
    logic [NUM_CH-1:0]    w_ev_drop;
    logic [NUM_CH-1:0]    w_ev_excl;
    logic                 w_excl_hit;
    logic [4*NUM_CH-1:0]  w_ev_flags;
    logic                 w_any_ev;

    logic [NUM_CH-1:0]    w_busy_nxt;
    logic [4*NUM_CH-1:0]  w_flags_nxt;
    logic [ERRCNT_W-1:0]  w_count_nxt;

    logic [NUM_CH-1:0]    r_busy;
    logic [4*NUM_CH-1:0]  r_flags;
    logic                 r_err_any;
    logic [ERRCNT_W-1:0]  r_count;

    // Per-channel handshake next-state, counters and protocol/timing events.
    always_comb begin
        w_excl_hit = multi_hot(i_ack & EXCL_MASK);
        for (int c = 0; c < NUM_CH; c++) begin
            w_state_nxt[c] = r_state[c];
            w_cnt_nxt[c]   = r_cnt[c];
            w_rcnt_nxt[c]  = r_rcnt[c];
            w_tdone_nxt[c] = r_tdone[c];
            w_ev_tout[c]   = 1'b0;
            w_ev_proto[c]  = 1'b0;
            w_ev_drop[c]   = 1'b0;
            w_ev_excl[c]   = i_cfg_enable & w_excl_hit & i_ack[c] & EXCL_MASK[c];
            if (!i_cfg_enable) begin
                w_state_nxt[c] = ST_IDLE;
                w_cnt_nxt[c]   = CNT_ZERO;
                w_rcnt_nxt[c]  = 2'd0;
                w_tdone_nxt[c] = 1'b0;
            end else begin
                case (r_state[c])
                    ST_IDLE: begin
                        case ({i_req[c], i_ack[c]})
                            2'b10: begin
                                w_state_nxt[c] = ST_REQ;
                                w_cnt_nxt[c]   = CNT_ONE;
                                w_tdone_nxt[c] = 1'b0;
                            end
                            2'b11: w_state_nxt[c] = ST_ACK;
                            2'b01: w_ev_proto[c] = 1'b1;
                            default: w_state_nxt[c] = ST_IDLE;
                        endcase
                    end
                    ST_REQ: begin
                        case ({i_req[c], i_ack[c]})
                            2'b10: begin
                                // At the limit the counter holds; the flag fires only once per transaction.
                                if ((i_cfg_tresp != CNT_ZERO) && (r_cnt[c] == i_cfg_tresp)) begin
                                    w_ev_tout[c]   = ~r_tdone[c];
                                    w_tdone_nxt[c] = 1'b1;
                                end else if (r_cnt[c] != CNT_MAX) begin
                                    w_cnt_nxt[c] = r_cnt[c] + CNT_ONE;
                                end else begin
                                    w_cnt_nxt[c] = r_cnt[c];
                                end
                            end
                            2'b11: w_state_nxt[c] = ST_ACK;
                            2'b00: begin
                                w_state_nxt[c] = ST_IDLE;
                                w_ev_proto[c]  = CH_MODE[c];
                            end
                            default: begin
                                w_state_nxt[c] = ST_REL;
                                w_rcnt_nxt[c]  = 2'd1;
                            end
                        endcase
                    end
                    ST_ACK: begin
                        case ({i_req[c], i_ack[c]})
                            2'b11: w_state_nxt[c] = ST_ACK;
                            2'b01: begin
                                w_state_nxt[c] = ST_REL;
                                w_rcnt_nxt[c]  = 2'd1;
                            end
                            2'b10: begin
                                w_ev_proto[c]  = 1'b1;
                                w_state_nxt[c] = ST_REQ;
                                w_cnt_nxt[c]   = CNT_ONE;
                                w_tdone_nxt[c] = 1'b0;
                            end
                            default: w_state_nxt[c] = ST_IDLE;
                        endcase
                    end
                    ST_REL: begin
                        case ({i_req[c], i_ack[c]})
                            2'b01: begin
                                // Ack still high one sample after release: flag once, then saturate.
                                w_ev_drop[c] = (r_rcnt[c] == 2'd1);
                                if (r_rcnt[c] != 2'd2) begin
                                    w_rcnt_nxt[c] = r_rcnt[c] + 2'd1;
                                end else begin
                                    w_rcnt_nxt[c] = r_rcnt[c];
                                end
                            end
                            2'b11: begin
                                w_ev_proto[c]  = 1'b1;
                                w_state_nxt[c] = ST_ACK;
                            end
                            2'b10: begin
                                w_state_nxt[c] = ST_REQ;
                                w_cnt_nxt[c]   = CNT_ONE;
                                w_tdone_nxt[c] = 1'b0;
                            end
                            default: w_state_nxt[c] = ST_IDLE;
                        endcase
                    end
                    default: w_state_nxt[c] = ST_IDLE;
                endcase
            end
            w_busy_nxt[c] = (w_state_nxt[c] != ST_IDLE);
        end
    end

    // Gather events into flag layout, apply clear priority and saturating count.
    always_comb begin
        w_ev_flags = {(4*NUM_CH){1'b0}};
        for (int c = 0; c < NUM_CH; c++) begin
            w_ev_flags[4*c +: 4] = {w_ev_excl[c], w_ev_drop[c], w_ev_proto[c], w_ev_tout[c]};
        end
        w_any_ev = |w_ev_flags;
        if (i_err_clr) begin
            w_flags_nxt = {(4*NUM_CH){1'b0}};
            w_count_nxt = ERR_ZERO;
        end else begin
            w_flags_nxt = r_flags | w_ev_flags;
            if (w_any_ev && (r_count != ERR_MAX)) begin
                w_count_nxt = r_count + ERR_ONE;
            end else begin
                w_count_nxt = r_count;
            end
        end
    end

    // State, counter and output registers.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_state[c] <= ST_IDLE;
                r_cnt[c]   <= CNT_ZERO;
                r_rcnt[c]  <= 2'd0;
            end
            r_tdone   <= {NUM_CH{1'b0}};
            r_busy    <= {NUM_CH{1'b0}};
            r_flags   <= {(4*NUM_CH){1'b0}};
            r_err_any <= 1'b0;
            r_count   <= ERR_ZERO;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_state[c] <= w_state_nxt[c];
                r_cnt[c]   <= w_cnt_nxt[c];
                r_rcnt[c]  <= w_rcnt_nxt[c];
            end
            r_tdone   <= w_tdone_nxt;
            r_busy    <= w_busy_nxt;
            r_flags   <= w_flags_nxt;
            r_err_any <= |w_flags_nxt;
            r_count   <= w_count_nxt;
        end
    end

    assign o_ch_busy   = r_busy;
    assign o_err_flags = r_flags;
    assign o_err_any   = r_err_any;
    assign o_err_count = r_count;

endmodule
